// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes {g,f,e,d,c,b,a},
// the BCD decoder, and a width helper for digit-index signals.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal codes decode to a dark digit rather than a glyph.
  function automatic seg_t bcd_to_seg(input logic [3:0] code);
    seg_t seg_v;
    case (code)
      4'd0:    seg_v = SEG_DIGIT[0];
      4'd1:    seg_v = SEG_DIGIT[1];
      4'd2:    seg_v = SEG_DIGIT[2];
      4'd3:    seg_v = SEG_DIGIT[3];
      4'd4:    seg_v = SEG_DIGIT[4];
      4'd5:    seg_v = SEG_DIGIT[5];
      4'd6:    seg_v = SEG_DIGIT[6];
      4'd7:    seg_v = SEG_DIGIT[7];
      4'd8:    seg_v = SEG_DIGIT[8];
      4'd9:    seg_v = SEG_DIGIT[9];
      default: seg_v = SEG_BLANK;
    endcase
    return seg_v;
  endfunction

  // Digit index width; a single-digit display still gets a 1-bit index.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-data bus between the time counters (master) and the scan driver (slave).
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    lz_blank;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output load, bcd_in, dp_in, blink_en, lz_blank,
    input  seg, dp, an
  );

  modport slave (
    input  load, bcd_in, dp_in, blink_en, lz_blank,
    output seg, dp, an
  );

endinterface

// File: rtl/seg7_scan_timer.sv
// Scan timing: slot counter, digit index, frame counter and blink phase.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 64,
  parameter int BLINK_SCANS = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [idx_width(NUM_DIGITS)-1:0]   idx,
  output logic                               slot_start,
  output logic                               in_dead,
  output logic                               blink_off
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_N    = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_SCANS - 1);

  logic [CNT_W-1:0] slot_cnt_r, slot_cnt_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [FRM_W-1:0] frame_cnt_r, frame_cnt_s;
  logic             blink_off_r, blink_off_s;

  // Next-state for the counter chain: slot wrap advances digit, digit wrap ends a frame.
  always_comb begin
    slot_cnt_s  = slot_cnt_r + CNT_W'(1);
    idx_s       = idx_r;
    frame_cnt_s = frame_cnt_r;
    blink_off_s = blink_off_r;
    if (slot_cnt_r == SLOT_LAST) begin
      slot_cnt_s = '0;
      if (idx_r == IDX_LAST) begin
        idx_s = '0;
        if (frame_cnt_r == FRM_LAST) begin
          frame_cnt_s = '0;
          blink_off_s = ~blink_off_r;
        end else begin
          frame_cnt_s = frame_cnt_r + FRM_W'(1);
        end
      end else begin
        idx_s = idx_r + IDX_W'(1);
      end
    end else begin
      slot_cnt_s = slot_cnt_r + CNT_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r  <= '0;
      idx_r       <= '0;
      frame_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else begin
      slot_cnt_r  <= slot_cnt_s;
      idx_r       <= idx_s;
      frame_cnt_r <= frame_cnt_s;
      blink_off_r <= blink_off_s;
    end
  end

  assign idx        = idx_r;
  assign slot_start = (slot_cnt_r == '0);
  assign in_dead    = (slot_cnt_r < DEAD_N);
  assign blink_off  = blink_off_r;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with leading-zero blanking,
// per-digit blink and anti-ghosting dead time. All pins are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int DEAD_CYCLES   = 64,
  parameter int BLINK_SCANS   = 256,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [IDX_W-1:0]      idx_s;
  logic                  slot_start_s, in_dead_s, blink_off_s;

  logic [BCD_W-1:0]      sh_bcd_r, snap_bcd_r, cur_bcd_s;
  logic [NUM_DIGITS-1:0] sh_dp_r, snap_dp_r, cur_dp_s;
  logic [NUM_DIGITS-1:0] sh_blink_r, snap_blink_r, cur_blink_s;
  logic [NUM_DIGITS-1:0] nonzero_s;
  logic [3:0]            digit_s;
  logic                  dp_req_s, blink_req_s, lz_hide_s;

  seg_t                  seg_s, seg_r;
  logic                  dp_s, dp_r;
  logic [NUM_DIGITS-1:0] an_s, an_r;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_SCANS (BLINK_SCANS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx_s),
    .slot_start (slot_start_s),
    .in_dead    (in_dead_s),
    .blink_off  (blink_off_s)
  );

  // Shadow capture of the display request on each load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bcd_r   <= '0;
      sh_dp_r    <= '0;
      sh_blink_r <= '0;
    end else if (bus.load) begin
      sh_bcd_r   <= bus.bcd_in;
      sh_dp_r    <= bus.dp_in;
      sh_blink_r <= bus.blink_en;
    end else begin
      sh_bcd_r   <= sh_bcd_r;
      sh_dp_r    <= sh_dp_r;
      sh_blink_r <= sh_blink_r;
    end
  end

  // Freeze the shadow at each slot start so a digit never tears mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd_r   <= '0;
      snap_dp_r    <= '0;
      snap_blink_r <= '0;
    end else if (slot_start_s) begin
      snap_bcd_r   <= sh_bcd_r;
      snap_dp_r    <= sh_dp_r;
      snap_blink_r <= sh_blink_r;
    end else begin
      snap_bcd_r   <= snap_bcd_r;
      snap_dp_r    <= snap_dp_r;
      snap_blink_r <= snap_blink_r;
    end
  end

  // Slot data: on the first cycle of a slot the snapshot is still loading, so bypass it.
  always_comb begin
    cur_bcd_s   = snap_bcd_r;
    cur_dp_s    = snap_dp_r;
    cur_blink_s = snap_blink_r;
    if (slot_start_s) begin
      cur_bcd_s   = sh_bcd_r;
      cur_dp_s    = sh_dp_r;
      cur_blink_s = sh_blink_r;
    end else begin
      cur_bcd_s   = snap_bcd_r;
      cur_dp_s    = snap_dp_r;
      cur_blink_s = snap_blink_r;
    end
  end

  // Per-digit selection and leading-zero test (this digit and all above it are zero).
  always_comb begin
    nonzero_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nonzero_s[k] = |cur_bcd_s[4*k +: 4];
    end
    digit_s     = cur_bcd_s[{idx_s, 2'b00} +: 4];
    dp_req_s    = cur_dp_s[idx_s];
    blink_req_s = cur_blink_s[idx_s];
    lz_hide_s   = bus.lz_blank && (idx_s != '0) && !(|(nonzero_s >> idx_s));
  end

  // Next pin values: dark during dead time, otherwise one anode plus decoded segments.
  always_comb begin
    seg_s = SEG_BLANK;
    dp_s  = 1'b1;
    an_s  = AN_IDLE;
    if (in_dead_s) begin
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
      an_s  = AN_IDLE;
    end else begin
      an_s = AN_IDLE ^ (NUM_DIGITS'(1) << idx_s);
      if (blink_off_s && blink_req_s) begin
        seg_s = SEG_BLANK;
        dp_s  = 1'b1;
      end else if (lz_hide_s) begin
        seg_s = SEG_BLANK;
        dp_s  = ~dp_req_s;
      end else begin
        seg_s = bcd_to_seg(digit_s);
        dp_s  = ~dp_req_s;
      end
    end
  end

  // Output pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      an_r  <= AN_IDLE;
    end else begin
      seg_r <= seg_s;
      dp_r  <= dp_s;
      an_r  <= an_s;
    end
  end

  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;
  assign bus.an  = an_r;

endmodule
